// File: rtl/spi_master_gen_if.sv
// Bus bundle for spi_master_gen: request/response handshake plus the SPI pins.
// The master modport is the SPI controller's view; the slave modport is the
// view of whatever sits around it (bus front end and the off-chip slave pins).
`timescale 1ns/1ps
interface spi_master_gen_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  logic              start;
  logic              ready;
  logic [DATA_W-1:0] tx_data;
  logic [CS_W-1:0]   cs_sel;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [DIV_W-1:0]  div;
  logic              busy;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              scl;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;

  modport master (
    input  start, tx_data, cs_sel, cpol, cpha, lsb_first, div, miso,
    output ready, busy, rx_data, rx_valid, scl, mosi, cs_n
  );

  modport slave (
    output start, tx_data, cs_sel, cpol, cpha, lsb_first, div, miso,
    input  ready, busy, rx_data, rx_valid, scl, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable word width, CPOL/CPHA mode, SCL
// divider, bit order and one-hot chip selects. Every output is a flop.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready, cs_n all high, scl follows cpol input, mosi low
// SETUP | cs_n[sel] low for H cycles before the first SCL edge
// XFER  | issuing SCL edges 1..2*DATA_W, one every H cycles
// HOLD  | H cycles after the last edge, cs_n[sel] still low
`timescale 1ns/1ps
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8
) (
  input logic             clk,
  input logic             rst,
  spi_master_gen_if.master bus
);
  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int EC_W = $clog2(2 * DATA_W + 1);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t state, state_nxt;

  // latched request
  logic [CS_W-1:0]   sel;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;
  logic [DIV_W-1:0]  div_r;

  // timing and shift datapath
  logic [DIV_W:0]    cnt;
  logic [EC_W-1:0]   edge_cnt;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;

  // output flops and their next values
  logic              scl_q, scl_d;
  logic              mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  logic              accept;
  logic              tick;
  logic              edge_now;
  logic [EC_W-1:0]   edge_nxt;
  logic              sample_now;
  logic              shift_now;
  logic              tx_bit;
  logic [DATA_W-1:0] tx_adv;
  logic [DATA_W-1:0] rx_in;
  logic [CS_W-1:0]   sel_nxt;

  // out-of-range selects are simply never accepted
  assign accept   = (state == IDLE) && bus.start && (int'(bus.cs_sel) < NUM_CS);
  assign tick     = (cnt == '0);
  assign edge_now = tick && ((state == SETUP) || (state == XFER));
  assign edge_nxt = edge_cnt + EC_W'(1);
  // odd edges are leading; cpha picks which parity samples
  assign sample_now = edge_now && (edge_nxt[0] ^ cpha_r);
  // the final edge never shifts, so mosi keeps the last bit through HOLD
  assign shift_now  = edge_now && !(edge_nxt[0] ^ cpha_r) && (edge_nxt != LAST_EDGE);
  assign tx_bit  = lsb_r ? tx_sh[0] : tx_sh[DATA_W-1];
  assign tx_adv  = lsb_r ? (tx_sh >> 1) : (tx_sh << 1);
  assign rx_in   = lsb_r ? {bus.miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], bus.miso};
  assign sel_nxt = accept ? bus.cs_sel : sel;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (accept) state_nxt = SETUP;
      SETUP, XFER: if (tick) state_nxt = (edge_nxt == LAST_EDGE) ? HOLD : XFER;
      HOLD:        if (tick) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // next values for the registered outputs
  always_comb begin
    scl_d      = scl_q;
    mosi_d     = mosi_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    ready_d    = (state_nxt == IDLE);
    busy_d     = (state_nxt != IDLE);
    cs_n_d     = '1;
    if (state_nxt != IDLE) cs_n_d = ~(NUM_CS'(1) << sel_nxt);
    case (state)
      IDLE: begin
        scl_d  = bus.cpol;
        mosi_d = 1'b0;
        if (accept && !bus.cpha)
          mosi_d = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
      end
      SETUP: begin
        scl_d = edge_now ? ~cpol_r : cpol_r;
        if (shift_now) mosi_d = tx_bit;
      end
      XFER: begin
        scl_d = edge_now ? ~scl_q : scl_q;
        if (shift_now) mosi_d = tx_bit;
      end
      HOLD: begin
        scl_d = cpol_r;
        if (tick) begin
          mosi_d     = 1'b0;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sh;
        end
      end
      default: ;
    endcase
  end

  // request latch, divider down-counter, edge counter and shift registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      div_r    <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
    end else if (accept) begin
      sel      <= bus.cs_sel;
      cpol_r   <= bus.cpol;
      cpha_r   <= bus.cpha;
      lsb_r    <= bus.lsb_first;
      div_r    <= bus.div;
      cnt      <= {1'b0, bus.div};
      edge_cnt <= '0;
      rx_sh    <= '0;
      // with cpha=0 the first bit is already on mosi, so pre-advance
      if (bus.cpha)           tx_sh <= bus.tx_data;
      else if (bus.lsb_first) tx_sh <= bus.tx_data >> 1;
      else                    tx_sh <= bus.tx_data << 1;
    end else if (state != IDLE) begin
      if (tick) begin
        cnt <= {1'b0, div_r};
        if (edge_now) edge_cnt <= edge_nxt;
      end else begin
        cnt <= cnt - (DIV_W + 1)'(1);
      end
      if (sample_now) rx_sh <= rx_in;
      if (shift_now)  tx_sh <= tx_adv;
    end
  end

  // output flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q      <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      scl_q      <= scl_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign bus.scl      = scl_q;
  assign bus.mosi     = mosi_q;
  assign bus.cs_n     = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.ready    = ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_master_gen.sv
// Testbench for spi_master_gen: three builds (8-bit, 12-bit, 4-bit), a small
// SPI slave model on the 8-bit build and a queue of expected received words.
`timescale 1ns/1ps
module tb_spi_master_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  spi_master_gen_if #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) if8();
  spi_master_gen_if #(.DATA_W(12), .NUM_CS(5), .DIV_W(8)) if12();
  spi_master_gen_if #(.DATA_W(4),  .NUM_CS(2), .DIV_W(8)) if4();

  spi_master_gen #(.DATA_W(8),  .NUM_CS(4), .DIV_W(8)) u_dut8  (.clk(clk), .rst(rst), .bus(if8));
  spi_master_gen #(.DATA_W(12), .NUM_CS(5), .DIV_W(8)) u_dut12 (.clk(clk), .rst(rst), .bus(if12));
  spi_master_gen #(.DATA_W(4),  .NUM_CS(2), .DIV_W(8)) u_dut4  (.clk(clk), .rst(rst), .bus(if4));

  logic loop8 = 1'b1;
  logic sl_miso = 1'b0;
  assign if8.miso  = loop8 ? if8.mosi : sl_miso;
  assign if12.miso = if12.mosi;
  assign if4.miso  = if4.mosi;

  // SPI slave model on the 8-bit build (MSB first)
  logic [7:0] sl_resp = 8'h3C;
  logic [7:0] sl_sh = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic sl_cpol = 1'b0, sl_cpha = 1'b0, sl_act = 1'b0, sl_scl = 1'b0, sl_now = 1'b0;
  int sl_sel = 0;
  always @(if8.cs_n or if8.scl) begin
    sl_now = (if8.cs_n[sl_sel] == 1'b0);
    if (sl_now && !sl_act) begin
      sl_sh = sl_resp;
      sl_rx = 8'h00;
      if (!sl_cpha) begin sl_miso = sl_sh[7]; sl_sh = sl_sh << 1; end
    end else if (sl_now && (if8.scl != sl_scl)) begin
      if ((if8.scl != sl_cpol) ^ sl_cpha) sl_rx = {sl_rx[6:0], if8.mosi};
      else begin sl_miso = sl_sh[7]; sl_sh = sl_sh << 1; end
    end
    sl_act = sl_now;
    sl_scl = if8.scl;
  end

  // drive one request into the 8-bit build and watch it until rx_valid
  task automatic run8(input logic [7:0] tx, input logic [1:0] sel, input logic pol, pha, lsb,
                      input logic [7:0] dv, input int budget,
                      output int lat, output int rises, output int cs_bad, output logic [7:0] rx);
    logic [3:0] cs_exp;
    logic prev;
    cs_exp = ~(4'b0001 << sel);
    @(negedge clk);
    if8.tx_data = tx; if8.cs_sel = sel; if8.cpol = pol; if8.cpha = pha;
    if8.lsb_first = lsb; if8.div = dv; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    lat = 0; rises = 0; cs_bad = 0; rx = 8'h00;
    prev = if8.scl;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (!prev && if8.scl) rises++;
      prev = if8.scl;
      if (if8.rx_valid) begin lat = n; rx = if8.rx_data; break; end
      if (if8.cs_n !== cs_exp) cs_bad++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({if8.scl, if8.mosi, if8.cs_n, if8.busy, if8.ready, if8.rx_valid} !== 9'b0_0_1111_0_1_0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %b want %b", {if8.scl, if8.mosi, if8.cs_n, if8.busy, if8.ready, if8.rx_valid}, 9'b0_0_1111_0_1_0);
    end
    tests_run++;
    if (if8.rx_data !== 8'h00) begin tests_failed++; $display("FAIL reset_rx_data: got %h want 00", if8.rx_data); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_loopback;
    int lat, rises, cs_bad;
    logic [7:0] rx;
    logic [31:0] exp;
    loop8 = 1'b1;
    exp_q.push_back(32'h0000_00DA);
    run8(8'hDA, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 40, lat, rises, cs_bad, rx);
    tests_run++;
    if (lat !== 18) begin tests_failed++; $display("FAIL m0_latency: got %0d want 18", lat); end
    tests_run++;
    if (rises !== 8) begin tests_failed++; $display("FAIL m0_scl_rises: got %0d want 8", rises); end
    tests_run++;
    if (cs_bad !== 0) begin tests_failed++; $display("FAIL m0_cs_window: %0d cycles not 1011", cs_bad); end
    tests_run++;
    if (if8.cs_n !== 4'hF || if8.ready !== 1'b1 || if8.busy !== 1'b0) begin
      tests_failed++; $display("FAIL m0_completion: cs_n %b ready %b busy %b want 1111 1 0", if8.cs_n, if8.ready, if8.busy);
    end
    exp = exp_q.pop_front();
    tests_run++;
    if ({24'h0, rx} !== exp) begin tests_failed++; $display("FAIL m0_rx: got %h want %h", rx, exp); end
  endtask

  task automatic test_modes;
    int lat, rises, cs_bad;
    logic [7:0] rx;
    logic [31:0] exp;
    logic pol, pha;
    loop8 = 1'b0;
    for (int m = 1; m < 4; m++) begin
      pol = m[1]; pha = m[0];
      sl_cpol = pol; sl_cpha = pha; sl_sel = 0; sl_resp = 8'h3C;
      @(negedge clk);
      if8.cpol = pol;
      repeat (2) @(negedge clk);
      tests_run++;
      if (if8.scl !== pol) begin tests_failed++; $display("FAIL mode%0d_idle_before: scl %b want %b", m, if8.scl, pol); end
      exp_q.push_back(32'h0000_003C);
      run8(8'hA5, 2'd0, pol, pha, 1'b0, 8'd2, 80, lat, rises, cs_bad, rx);
      tests_run++;
      if (lat !== 52) begin tests_failed++; $display("FAIL mode%0d_latency: got %0d want 52", m, lat); end
      exp = exp_q.pop_front();
      tests_run++;
      if ({24'h0, rx} !== exp) begin tests_failed++; $display("FAIL mode%0d_rx: got %h want %h", m, rx, exp); end
      tests_run++;
      if (sl_rx !== 8'hA5) begin tests_failed++; $display("FAIL mode%0d_slave_rx: got %h want a5", m, sl_rx); end
      tests_run++;
      if (cs_bad !== 0) begin tests_failed++; $display("FAIL mode%0d_cs_window: %0d bad cycles", m, cs_bad); end
      @(negedge clk);
      tests_run++;
      if (if8.scl !== pol) begin tests_failed++; $display("FAIL mode%0d_idle_after: scl %b want %b", m, if8.scl, pol); end
    end
    loop8 = 1'b1;
    if8.cpol = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, bad;
    logic [7:0] rx1, rx2;
    logic [31:0] exp;
    loop8 = 1'b1;
    @(negedge clk);
    if8.tx_data = 8'h5A; if8.cs_sel = 2'd1; if8.cpol = 1'b0; if8.cpha = 1'b0;
    if8.lsb_first = 1'b0; if8.div = 8'd0; if8.start = 1'b1;
    exp_q.push_back(32'h0000_005A);
    @(posedge clk);
    #1;
    // start stays high; these new inputs belong to the next request
    if8.tx_data = 8'h3C; if8.cs_sel = 2'd3;
    exp_q.push_back(32'h0000_003C);
    lat1 = 0; bad = 0; rx1 = 8'h00;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (if8.rx_valid) begin lat1 = n; rx1 = if8.rx_data; break; end
      if (if8.cs_n !== 4'b1101) bad++;
    end
    tests_run++;
    if (lat1 !== 18) begin tests_failed++; $display("FAIL b2b_latency1: got %0d want 18", lat1); end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL b2b_busy_ignore: %0d cycles cs_n not 1101", bad); end
    exp = exp_q.pop_front();
    tests_run++;
    if ({24'h0, rx1} !== exp) begin tests_failed++; $display("FAIL b2b_rx1: got %h want %h", rx1, exp); end
    tests_run++;
    if (if8.cs_n !== 4'hF) begin tests_failed++; $display("FAIL b2b_gap: cs_n %b want 1111", if8.cs_n); end
    @(negedge clk);
    tests_run++;
    if (if8.cs_n !== 4'b0111 || if8.busy !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_second_accept: cs_n %b busy %b want 0111 1", if8.cs_n, if8.busy);
    end
    if8.start = 1'b0;
    lat2 = 0; rx2 = 8'h00;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (n == 5) if8.start = 1'b1;
      if (n == 6) if8.start = 1'b0;
      if (if8.rx_valid) begin lat2 = n; rx2 = if8.rx_data; break; end
    end
    tests_run++;
    if (lat2 !== 18) begin tests_failed++; $display("FAIL b2b_latency2: got %0d want 18", lat2); end
    exp = exp_q.pop_front();
    tests_run++;
    if ({24'h0, rx2} !== exp) begin tests_failed++; $display("FAIL b2b_rx2: got %h want %h", rx2, exp); end
    @(negedge clk);
    tests_run++;
    if (if8.cs_n !== 4'hF || if8.ready !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_idle_after: cs_n %b ready %b want 1111 1", if8.cs_n, if8.ready);
    end
  endtask

  task automatic test_reject;
    int bad;
    bad = 0;
    @(negedge clk);
    if12.tx_data = 12'hFFF; if12.cs_sel = 3'd5; if12.div = 8'd0; if12.start = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 3) if12.cs_sel = 3'd7;
      if (if12.ready !== 1'b1 || if12.busy !== 1'b0 || if12.cs_n !== 5'h1F) bad++;
    end
    if12.start = 1'b0;
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL reject_sel: %0d cycles accepted or busy", bad); end
  endtask

  task automatic test_lsb12;
    int lat, nb;
    logic prev;
    logic [11:0] cap, rx;
    logic [31:0] exp;
    @(negedge clk);
    if12.tx_data = 12'h801; if12.cs_sel = 3'd4; if12.cpol = 1'b0; if12.cpha = 1'b0;
    if12.lsb_first = 1'b1; if12.div = 8'd1; if12.start = 1'b1;
    exp_q.push_back(32'h0000_0801);
    @(posedge clk);
    #1 if12.start = 1'b0;
    lat = 0; nb = 0; cap = 12'h000; rx = 12'h000;
    prev = if12.scl;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (!prev && if12.scl) begin
        if (nb < 12) cap[nb] = if12.mosi;
        nb++;
      end
      prev = if12.scl;
      if (if12.rx_valid) begin lat = n; rx = if12.rx_data; break; end
    end
    tests_run++;
    if (nb !== 12 || cap !== 12'h801) begin tests_failed++; $display("FAIL lsb_mosi_bits: %0d bits %h want 12 bits 801", nb, cap); end
    tests_run++;
    if (lat !== 51) begin tests_failed++; $display("FAIL lsb_latency: got %0d want 51", lat); end
    exp = exp_q.pop_front();
    tests_run++;
    if ({20'h0, rx} !== exp) begin tests_failed++; $display("FAIL lsb_rx: got %h want %h", rx, exp); end
  endtask

  task automatic test_reset_mid;
    int lat, rises, cs_bad, spurious;
    logic [7:0] rx;
    logic [31:0] exp;
    loop8 = 1'b1;
    @(negedge clk);
    if8.cpol = 1'b1;
    repeat (2) @(negedge clk);
    if8.tx_data = 8'h77; if8.cs_sel = 2'd0; if8.cpha = 1'b0; if8.lsb_first = 1'b0;
    if8.div = 8'd1; if8.start = 1'b1;
    @(posedge clk);
    #1 if8.start = 1'b0;
    repeat (7) @(negedge clk);
    tests_run++;
    if (if8.busy !== 1'b1) begin tests_failed++; $display("FAIL rstmid_busy_before: busy %b want 1", if8.busy); end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({if8.cs_n, if8.scl, if8.mosi, if8.busy, if8.ready, if8.rx_valid} !== 9'b1111_0_0_0_1_0) begin
      tests_failed++;
      $display("FAIL rstmid_async: got %b want %b", {if8.cs_n, if8.scl, if8.mosi, if8.busy, if8.ready, if8.rx_valid}, 9'b1111_0_0_0_1_0);
    end
    tests_run++;
    if (if8.rx_data !== 8'h00) begin tests_failed++; $display("FAIL rstmid_rx_data: got %h want 00", if8.rx_data); end
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (if8.rx_valid) spurious++;
    end
    tests_run++;
    if (spurious !== 0) begin tests_failed++; $display("FAIL rstmid_no_valid: %0d pulses want 0", spurious); end
    exp_q.push_back(32'h0000_0096);
    run8(8'h96, 2'd0, 1'b1, 1'b0, 1'b0, 8'd1, 60, lat, rises, cs_bad, rx);
    tests_run++;
    if (lat !== 35) begin tests_failed++; $display("FAIL rstmid_fresh_latency: got %0d want 35", lat); end
    exp = exp_q.pop_front();
    tests_run++;
    if ({24'h0, rx} !== exp) begin tests_failed++; $display("FAIL rstmid_fresh_rx: got %h want %h", rx, exp); end
  endtask

  task automatic test_div255;
    int lat, edges, first, last, bad;
    logic prev;
    logic [3:0] rx;
    logic [31:0] exp;
    @(negedge clk);
    if4.tx_data = 4'h9; if4.cs_sel = 1'b1; if4.cpol = 1'b0; if4.cpha = 1'b0;
    if4.lsb_first = 1'b0; if4.div = 8'hFF; if4.start = 1'b1;
    exp_q.push_back(32'h0000_0009);
    @(posedge clk);
    #1 if4.start = 1'b0;
    lat = 0; edges = 0; first = 0; last = 0; bad = 0; rx = 4'h0;
    prev = if4.scl;
    for (int n = 1; n <= 2400; n++) begin
      @(negedge clk);
      if (if4.scl != prev) begin
        edges++;
        if (edges == 1) first = n;
        else if (n - last != 256) bad++;
        last = n;
      end
      prev = if4.scl;
      if (if4.rx_valid) begin lat = n; rx = if4.rx_data; break; end
    end
    tests_run++;
    if (first !== 257) begin tests_failed++; $display("FAIL div255_first_edge: got %0d want 257", first); end
    tests_run++;
    if (bad !== 0 || edges !== 8) begin tests_failed++; $display("FAIL div255_spacing: %0d edges %0d bad gaps want 8 0", edges, bad); end
    tests_run++;
    if (lat !== 2305) begin tests_failed++; $display("FAIL div255_latency: got %0d want 2305", lat); end
    exp = exp_q.pop_front();
    tests_run++;
    if ({28'h0, rx} !== exp) begin tests_failed++; $display("FAIL div255_rx: got %h want %h", rx, exp); end
  endtask

  initial begin
    if8.start = 1'b0;  if8.tx_data = '0;  if8.cs_sel = '0;  if8.cpol = 1'b0;
    if8.cpha = 1'b0;   if8.lsb_first = 1'b0; if8.div = '0;
    if12.start = 1'b0; if12.tx_data = '0; if12.cs_sel = '0; if12.cpol = 1'b0;
    if12.cpha = 1'b0;  if12.lsb_first = 1'b0; if12.div = '0;
    if4.start = 1'b0;  if4.tx_data = '0;  if4.cs_sel = '0;  if4.cpol = 1'b0;
    if4.cpha = 1'b0;   if4.lsb_first = 1'b0; if4.div = '0;
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_back_to_back();
    test_reject();
    test_lsb12();
    test_reset_mid();
    test_div255();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover: %0d entries want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
